// File: rtl/tc_bridge_cp0_if.sv
// CPU-side bus of the system-control block: CP0 request, exception inputs and device port.
interface tc_bridge_cp0_if;
    logic        interrupt;
    logic [1:0]  cp0_op;
    logic [4:0]  cp0_addr;
    logic [31:0] cp0_wdata;
    logic [31:0] epc_in;
    logic        bd;
    logic [4:0]  exc_in;
    logic [31:0] mem_addr;
    logic [1:0]  mem_mode;
    logic [31:0] mem_wdata;
    logic        int_req;
    logic [31:0] epc_out;
    logic [31:0] cp0_rdata;
    logic [31:0] dev_rdata;
    logic [4:0]  dev_exc;

    modport master (
        output interrupt, cp0_op, cp0_addr, cp0_wdata, epc_in, bd, exc_in,
               mem_addr, mem_mode, mem_wdata,
        input  int_req, epc_out, cp0_rdata, dev_rdata, dev_exc
    );

    modport slave (
        input  interrupt, cp0_op, cp0_addr, cp0_wdata, epc_in, bd, exc_in,
               mem_addr, mem_mode, mem_wdata,
        output int_req, epc_out, cp0_rdata, dev_rdata, dev_exc
    );
endinterface

// File: rtl/tc_bridge_cp0.sv
// CP0 (SR/Cause/EPC/PRId), device bridge and two count-down timers beside the MEM stage.
module tc_bridge_cp0 #(
    parameter logic [31:0] TC0_BASE = 32'h0000_7F00,
    parameter logic [31:0] TC1_BASE = 32'h0000_7F10,
    parameter logic [31:0] PRID     = 32'h0000_0001
) (
    input logic            clk,
    input logic            reset,
    tc_bridge_cp0_if.slave bus
);
    localparam logic [1:0] OP_MTC0 = 2'd2;
    localparam logic [1:0] OP_ERET = 2'd3;
    localparam logic [1:0] MODE_RD = 2'd1;
    localparam logic [1:0] MODE_WR = 2'd2;

    typedef enum logic [1:0] {T_IDLE, T_LOAD, T_CNT, T_INT} tstate_t;

    function automatic logic [31:0] word_align(input logic [31:0] a);
        return a & ~32'd3;
    endfunction

    function automatic logic [31:0] timer_reg(input logic [1:0] idx, input logic [3:0] c,
                                              input logic [31:0] p, input logic [31:0] n);
        case (idx)
            2'd0:    return {28'd0, c};
            2'd1:    return p;
            2'd2:    return n;
            default: return 32'd0;
        endcase
    endfunction

    logic [3:0]  ctrl   [2];
    logic [31:0] preset [2];
    logic [31:0] count  [2];
    tstate_t     tstate [2];
    logic [1:0]  flag;
    logic [1:0]  irq;

    logic [5:0]  sr_im;
    logic        sr_exl;
    logic        sr_ie;
    logic        cause_bd;
    logic [5:0]  cause_ip;
    logic [4:0]  cause_exc;
    logic [31:0] epc;

    logic [5:0]  hw_lines;
    logic        hw_pend;
    logic        take;
    logic [31:0] sr_val;
    logic [31:0] cause_val;
    logic [31:0] cp0_rdata;

    logic [1:0]  hit;
    logic [1:0]  reg_idx;
    logic        is_rd;
    logic        is_wr;
    logic        wr_ok;
    logic [4:0]  dev_exc;

    assign irq       = {ctrl[1][3] & flag[1], ctrl[0][3] & flag[0]};
    assign hw_lines  = {3'b000, bus.interrupt, irq};
    assign hw_pend   = sr_ie & (|(sr_im & hw_lines));
    assign take      = !sr_exl & (hw_pend | (bus.exc_in != 5'd0));
    assign sr_val    = {16'd0, sr_im, 8'd0, sr_exl, sr_ie};
    assign cause_val = {cause_bd, 15'd0, cause_ip, 3'd0, cause_exc, 2'd0};

    always_comb begin
        cp0_rdata = 32'd0;
        case (bus.cp0_addr)
            5'd12:   cp0_rdata = sr_val;
            5'd13:   cp0_rdata = cause_val;
            5'd14:   cp0_rdata = epc;
            5'd15:   cp0_rdata = PRID;
            default: cp0_rdata = 32'd0;
        endcase
    end

    // Bridge decode; both timer bases are assumed 16-byte aligned.
    assign reg_idx = bus.mem_addr[3:2];
    assign hit[0]  = (bus.mem_addr[31:4] == TC0_BASE[31:4]) && (reg_idx != 2'b11) &&
                     (bus.mem_addr[1:0] == 2'b00);
    assign hit[1]  = (bus.mem_addr[31:4] == TC1_BASE[31:4]) && (reg_idx != 2'b11) &&
                     (bus.mem_addr[1:0] == 2'b00);
    assign is_rd   = (bus.mem_mode == MODE_RD);
    assign is_wr   = (bus.mem_mode == MODE_WR);

    always_comb begin
        dev_exc = 5'd0;
        if (is_rd && (hit == 2'b00))
            dev_exc = 5'd4;
        else if (is_wr && ((hit == 2'b00) || (reg_idx == 2'd2)))
            dev_exc = 5'd5;
    end

    assign wr_ok         = is_wr && (dev_exc == 5'd0) && !take;
    assign bus.dev_exc   = dev_exc;
    assign bus.dev_rdata = hit[0] ? timer_reg(reg_idx, ctrl[0], preset[0], count[0]) :
                           hit[1] ? timer_reg(reg_idx, ctrl[1], preset[1], count[1]) : 32'd0;
    assign bus.int_req   = take;
    assign bus.epc_out   = epc;
    assign bus.cp0_rdata = cp0_rdata;

    // CP0 state: an accepted interrupt/exception outranks ERET and MTC0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sr_im     <= 6'd0;
            sr_exl    <= 1'b0;
            sr_ie     <= 1'b0;
            cause_bd  <= 1'b0;
            cause_ip  <= 6'd0;
            cause_exc <= 5'd0;
            epc       <= 32'd0;
        end else begin
            cause_ip <= hw_lines;
            if (take) begin
                sr_exl    <= 1'b1;
                cause_exc <= hw_pend ? 5'd0 : bus.exc_in;
                cause_bd  <= bus.bd;
                epc       <= word_align(bus.bd ? bus.epc_in - 32'd4 : bus.epc_in);
            end else if (bus.cp0_op == OP_ERET) begin
                sr_exl <= 1'b0;
            end else if (bus.cp0_op == OP_MTC0) begin
                if (bus.cp0_addr == 5'd12) begin
                    sr_im  <= bus.cp0_wdata[15:10];
                    sr_exl <= bus.cp0_wdata[1];
                    sr_ie  <= bus.cp0_wdata[0];
                end else if (bus.cp0_addr == 5'd14) begin
                    epc <= word_align(bus.cp0_wdata);
                end
            end
        end
    end

    // Timers: a CTRL write freezes the FSM for that cycle so the new EN is seen next cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                ctrl[i]   <= 4'd0;
                preset[i] <= 32'd0;
                count[i]  <= 32'd0;
                tstate[i] <= T_IDLE;
                flag[i]   <= 1'b0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (wr_ok && hit[i] && (reg_idx == 2'd1))
                    preset[i] <= bus.mem_wdata;
                if (wr_ok && hit[i] && (reg_idx == 2'd0)) begin
                    ctrl[i] <= bus.mem_wdata[3:0];
                    flag[i] <= 1'b0;
                end else begin
                    case (tstate[i])
                        T_IDLE: if (ctrl[i][0]) tstate[i] <= T_LOAD;
                        T_LOAD: begin
                            count[i]  <= preset[i];
                            tstate[i] <= T_CNT;
                        end
                        T_CNT: begin
                            if (!ctrl[i][0]) begin
                                tstate[i] <= T_IDLE;
                            end else if (count[i] > 32'd1) begin
                                count[i] <= count[i] - 32'd1;
                            end else begin
                                count[i]  <= 32'd0;
                                flag[i]   <= 1'b1;
                                tstate[i] <= T_INT;
                            end
                        end
                        default: begin
                            if (ctrl[i][2:1] == 2'd1) begin
                                flag[i]   <= 1'b0;
                                tstate[i] <= T_LOAD;
                            end else begin
                                ctrl[i][0] <= 1'b0;
                                tstate[i]  <= T_IDLE;
                            end
                        end
                    endcase
                end
            end
        end
    end
endmodule

// File: tb/tb_tc_bridge_cp0.sv
// Directed bench for tc_bridge_cp0: CP0 exceptions, bridge decode and timer behaviour.
module tb_tc_bridge_cp0;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   failures = 0;

    tc_bridge_cp0_if bus ();

    tc_bridge_cp0 dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not end, got running, expected finished");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mtc0(input logic [4:0] addr, input logic [31:0] data);
        bus.cp0_op = 2'd2;
        bus.cp0_addr = addr;
        bus.cp0_wdata = data;
        tick();
        bus.cp0_op = 2'd0;
    endtask

    task automatic eret();
        bus.cp0_op = 2'd3;
        tick();
        bus.cp0_op = 2'd0;
    endtask

    task automatic dev_wr(input logic [31:0] addr, input logic [31:0] data);
        bus.mem_mode = 2'd2;
        bus.mem_addr = addr;
        bus.mem_wdata = data;
        tick();
        bus.mem_mode = 2'd0;
    endtask

    task automatic chk_cp0(input string tag, input logic [4:0] addr, input logic [31:0] exp);
        bus.cp0_addr = addr;
        #1;
        chk(tag, bus.cp0_rdata, exp);
    endtask

    task automatic chk_dev(input string tag, input logic [31:0] addr,
                           input logic [31:0] exp_data, input logic [4:0] exp_exc);
        bus.mem_mode = 2'd1;
        bus.mem_addr = addr;
        #1;
        chk(tag, bus.dev_rdata, exp_data);
        chk({tag, "_exc"}, {27'd0, bus.dev_exc}, {27'd0, exp_exc});
        bus.mem_mode = 2'd0;
    endtask

    initial begin
        reset = 1'b1;
        bus.interrupt = 1'b0;
        bus.cp0_op = 2'd0;
        bus.cp0_addr = 5'd0;
        bus.cp0_wdata = 32'd0;
        bus.epc_in = 32'd0;
        bus.bd = 1'b0;
        bus.exc_in = 5'd0;
        bus.mem_addr = 32'd0;
        bus.mem_mode = 2'd0;
        bus.mem_wdata = 32'd0;
        tick();
        tick();
        reset = 1'b0;
        chk("rst_intreq", {31'd0, bus.int_req}, 32'd0);
        chk("rst_epc_out", bus.epc_out, 32'd0);
        chk_cp0("rst_cause", 5'd13, 32'd0);
        chk_cp0("prid", 5'd15, 32'd1);
        chk_cp0("bad_cp0_addr", 5'd3, 32'd0);

        // Reset while timer0 is mid-count.
        mtc0(5'd12, 32'h0000_0401);
        mtc0(5'd14, 32'h0000_1238);
        dev_wr(32'h7F04, 32'd10);
        dev_wr(32'h7F00, 32'h1);
        for (int k = 0; k < 5; k++) tick();
        chk_dev("t1_count_pre", 32'h7F08, 32'd7, 5'd0);
        reset = 1'b1;
        #1;
        chk_dev("t1_count_rst", 32'h7F08, 32'd0, 5'd0);
        chk_dev("t1_ctrl_rst", 32'h7F00, 32'd0, 5'd0);
        chk_cp0("t1_sr_rst", 5'd12, 32'd0);
        chk_cp0("t1_epc_rst", 5'd14, 32'd0);
        chk("t1_intreq_rst", {31'd0, bus.int_req}, 32'd0);
        tick();
        reset = 1'b0;

        // One-shot timer0 raises irq0 five cycles after the CTRL write.
        mtc0(5'd12, 32'h0000_0401);
        dev_wr(32'h7F04, 32'd3);
        dev_wr(32'h7F00, 32'h9);
        bus.epc_in = 32'h0000_2010;
        bus.bd = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            tick();
            chk($sformatf("t2_intreq_k%0d", k), {31'd0, bus.int_req}, (k == 5) ? 32'd1 : 32'd0);
        end
        tick();
        chk_cp0("t2_cause", 5'd13, 32'h0000_0400);
        chk_cp0("t2_sr", 5'd12, 32'h0000_0403);
        chk("t2_epc", bus.epc_out, 32'h0000_2010);
        chk("t2_intreq_exl", {31'd0, bus.int_req}, 32'd0);
        chk_dev("t2_ctrl_en_clr", 32'h7F00, 32'h8, 5'd0);

        // Software exception in a delay slot, with a competing ERET.
        dev_wr(32'h7F00, 32'h0);
        eret();
        chk_cp0("t3_sr_eret", 5'd12, 32'h0000_0401);
        bus.exc_in = 5'd10;
        bus.bd = 1'b1;
        bus.epc_in = 32'h0000_3010;
        bus.cp0_op = 2'd3;
        #1;
        chk("t3_intreq", {31'd0, bus.int_req}, 32'd1);
        tick();
        bus.exc_in = 5'd0;
        bus.bd = 1'b0;
        bus.cp0_op = 2'd0;
        chk("t3_epc", bus.epc_out, 32'h0000_300C);
        chk_cp0("t3_cause", 5'd13, 32'h8000_0028);
        chk_cp0("t3_sr_exl", 5'd12, 32'h0000_0403);
        eret();
        chk_cp0("t3_sr_eret2", 5'd12, 32'h0000_0401);

        // Bridge decode and error cases.
        bus.mem_mode = 2'd2;
        bus.mem_addr = 32'h7F08;
        bus.mem_wdata = 32'h55;
        #1;
        chk("t4_wr_count_exc", {27'd0, bus.dev_exc}, 32'd5);
        tick();
        bus.mem_mode = 2'd0;
        chk_dev("t4_count_kept", 32'h7F08, 32'd0, 5'd0);
        chk_dev("t4_rd_unmapped", 32'h7F20, 32'd0, 5'd4);
        chk_dev("t4_rd_preset", 32'h7F04, 32'd3, 5'd0);
        chk_dev("t4_rd_misalign", 32'h7F06, 32'd0, 5'd4);
        chk_dev("t4_rd_gap", 32'h7F0C, 32'd0, 5'd4);
        dev_wr(32'h7F16, 32'h1111);
        dev_wr(32'h7F14, 32'hABCD);
        chk_dev("t4_tc1_preset", 32'h7F14, 32'hABCD, 5'd0);
        mtc0(5'd13, 32'hFFFF_FFFF);
        chk_cp0("t4_cause_ro", 5'd13, 32'h8000_0028);

        // Periodic timer0 with EXL set: irq pulses are visible in Cause.IP only.
        mtc0(5'd12, 32'h0000_0403);
        dev_wr(32'h7F04, 32'd2);
        bus.cp0_addr = 5'd13;
        dev_wr(32'h7F00, 32'hB);
        for (int k = 1; k <= 12; k++) begin
            tick();
            chk($sformatf("t5_intreq_k%0d", k), {31'd0, bus.int_req}, 32'd0);
            chk($sformatf("t5_ip_k%0d", k), {26'd0, bus.cp0_rdata[15:10]},
                (k == 5 || k == 9) ? 32'd1 : 32'd0);
        end
        dev_wr(32'h7F00, 32'h0);
        eret();
        tick();
        chk("t5_quiet", {31'd0, bus.int_req}, 32'd0);

        // MTC0 EPC and a timer write are both suppressed by a same-cycle exception.
        bus.exc_in = 5'd4;
        bus.bd = 1'b0;
        bus.epc_in = 32'h0000_2000;
        bus.cp0_op = 2'd2;
        bus.cp0_addr = 5'd14;
        bus.cp0_wdata = 32'h0000_3007;
        bus.mem_mode = 2'd2;
        bus.mem_addr = 32'h7F04;
        bus.mem_wdata = 32'h99;
        #1;
        chk("t6_intreq", {31'd0, bus.int_req}, 32'd1);
        tick();
        bus.exc_in = 5'd0;
        bus.cp0_op = 2'd0;
        bus.mem_mode = 2'd0;
        chk("t6_epc_exc", bus.epc_out, 32'h0000_2000);
        chk_cp0("t6_cause", 5'd13, 32'h0000_0010);
        chk_dev("t6_preset_kept", 32'h7F04, 32'd2, 5'd0);
        eret();
        mtc0(5'd14, 32'h0000_3007);
        chk("t6_epc_mtc0", bus.epc_out, 32'h0000_3004);

        // External interrupt beats a pending exception code.
        mtc0(5'd12, 32'h0000_1001);
        bus.interrupt = 1'b1;
        bus.exc_in = 5'd7;
        bus.epc_in = 32'h0000_4000;
        #1;
        chk("t7_intreq", {31'd0, bus.int_req}, 32'd1);
        tick();
        bus.interrupt = 1'b0;
        bus.exc_in = 5'd0;
        chk_cp0("t7_cause", 5'd13, 32'h0000_1000);
        chk_cp0("t7_sr", 5'd12, 32'h0000_1003);
        chk("t7_epc", bus.epc_out, 32'h0000_4000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
